// File: rtl/stk_pkg.sv
// Shared types and sizing for the stack pipeline writeback stage.
package stk_pkg;

   localparam int unsigned ENGS_N  = 4;
   localparam int unsigned PTR_W   = 5;
   localparam int unsigned DAT_W   = 128;
   localparam int unsigned ENGID_W = $clog2(ENGS_N);
   localparam int unsigned CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_CLR  = 2'd3
   } opcode_t;

   typedef enum logic [1:0] {
      ST_OKAY  = 2'd0,
      ST_FULL  = 2'd1,
      ST_EMPTY = 2'd2
   } status_t;

   typedef logic [PTR_W-1:0]   ptr_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [ENGID_W-1:0] engid_t;
   typedef logic [DAT_W-1:0]   dat_t;

   typedef struct packed {
      logic head_vld;
      ptr_t head_ptr;
      logic tail_vld;
      ptr_t tail_ptr;
      cnt_t cnt;
   } ctxt_t;

   // Full stack holds exactly 2**PTR_W lines.
   localparam cnt_t CNT_MAX = cnt_t'(1 << PTR_W);

endpackage

// File: rtl/stk_pipe_wrbk_ctxt.sv
// Architectural per-engine stack context: one write port, all entries read out flat.
module stk_pipe_wrbk_ctxt
   import stk_pkg::*;
(
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     wr_en,
   input  engid_t                   wr_idx,
   input  ctxt_t                    wr_ctxt,
   output ctxt_t [ENGS_N-1:0]       o_ctxt_r
);

   ctxt_t [ENGS_N-1:0] ctxt_q;
   ctxt_t [ENGS_N-1:0] ctxt_d;

   always_comb begin
      ctxt_d = ctxt_q;
      if (wr_en) begin
         ctxt_d[wr_idx] = wr_ctxt;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ctxt_q <= '0;
      end else begin
         ctxt_q <= ctxt_d;
      end
   end

   assign o_ctxt_r = ctxt_q;

endmodule

// File: rtl/stk_pipe_wrbk.sv
// Writeback stage: commits stack context, frees popped lines, issues per-engine responses.
module stk_pipe_wrbk
   import stk_pkg::*;
(
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      i_wrbk_uc_vld_r,
   input  engid_t                    i_wrbk_uc_engid_r,
   input  opcode_t                   i_wrbk_uc_opcode_r,
   input  status_t                   i_wrbk_uc_status_r,
   input  logic                      i_wrbk_uc_head_vld_r,
   input  ptr_t                      i_wrbk_uc_head_ptr_r,
   input  logic                      i_wrbk_uc_tail_vld_r,
   input  ptr_t                      i_wrbk_uc_tail_ptr_r,
   input  dat_t                      i_wrbk_uc_dat_r,
   output logic [ENGS_N-1:0]         o_ctxt_head_vld_r,
   output logic [ENGS_N*PTR_W-1:0]   o_ctxt_head_ptr_r,
   output logic [ENGS_N-1:0]         o_ctxt_tail_vld_r,
   output logic [ENGS_N*PTR_W-1:0]   o_ctxt_tail_ptr_r,
   output logic [ENGS_N*CNT_W-1:0]   o_ctxt_cnt_r,
   output logic                      o_dealloc_vld,
   output ptr_t                      o_dealloc_ptr,
   output logic [ENGS_N-1:0]         o_rsp_vld,
   output status_t                   o_rsp_status,
   output dat_t                      o_rsp_dat
);

   ctxt_t [ENGS_N-1:0] ctxt_r;
   ctxt_t              cur_ctxt;
   ctxt_t              nxt_ctxt;
   logic               op_vld;
   logic               push_ok;
   logic               pop_ok;
   logic               clr_ok;
   logic               wr_en;

   logic [ENGS_N-1:0]  rsp_vld_q,     rsp_vld_d;
   status_t            rsp_status_q,  rsp_status_d;
   dat_t               rsp_dat_q,     rsp_dat_d;
   logic               dealloc_vld_q, dealloc_vld_d;
   ptr_t               dealloc_ptr_q, dealloc_ptr_d;

   // Opcode/status decode and next context for the addressed engine.
   always_comb begin
      op_vld   = i_wrbk_uc_vld_r && (i_wrbk_uc_opcode_r != OP_NOP);
      push_ok  = op_vld && (i_wrbk_uc_status_r == ST_OKAY) && (i_wrbk_uc_opcode_r == OP_PUSH);
      pop_ok   = op_vld && (i_wrbk_uc_status_r == ST_OKAY) && (i_wrbk_uc_opcode_r == OP_POP);
      clr_ok   = op_vld && (i_wrbk_uc_status_r == ST_OKAY) && (i_wrbk_uc_opcode_r == OP_CLR);
      wr_en    = push_ok || pop_ok || clr_ok;
      cur_ctxt = ctxt_r[i_wrbk_uc_engid_r];
      nxt_ctxt = cur_ctxt;
      if (push_ok) begin
         nxt_ctxt.head_vld = i_wrbk_uc_head_vld_r;
         nxt_ctxt.head_ptr = i_wrbk_uc_head_ptr_r;
         nxt_ctxt.cnt      = (cur_ctxt.cnt == CNT_MAX) ? cur_ctxt.cnt : cur_ctxt.cnt + cnt_t'(1);
         if (i_wrbk_uc_tail_vld_r) begin
            nxt_ctxt.tail_vld = 1'b1;
            nxt_ctxt.tail_ptr = i_wrbk_uc_tail_ptr_r;
         end
      end else if (pop_ok) begin
         nxt_ctxt.head_vld = i_wrbk_uc_head_vld_r;
         nxt_ctxt.head_ptr = i_wrbk_uc_head_ptr_r;
         nxt_ctxt.cnt      = (cur_ctxt.cnt == cnt_t'(0)) ? cur_ctxt.cnt : cur_ctxt.cnt - cnt_t'(1);
         if (!i_wrbk_uc_head_vld_r) begin
            nxt_ctxt.tail_vld = 1'b0;
         end
      end else if (clr_ok) begin
         nxt_ctxt = '0;
      end
   end

   stk_pipe_wrbk_ctxt u_ctxt (
      .clk      (clk),
      .arst_n   (arst_n),
      .wr_en    (wr_en),
      .wr_idx   (i_wrbk_uc_engid_r),
      .wr_ctxt  (nxt_ctxt),
      .o_ctxt_r (ctxt_r)
   );

   // Response and dealloc; dealloc frees the head line as it stood before the pop.
   always_comb begin
      rsp_vld_d     = '0;
      rsp_status_d  = rsp_status_q;
      rsp_dat_d     = '0;
      dealloc_vld_d = 1'b0;
      dealloc_ptr_d = dealloc_ptr_q;
      if (op_vld) begin
         rsp_vld_d    = ENGS_N'(1) << i_wrbk_uc_engid_r;
         rsp_status_d = i_wrbk_uc_status_r;
      end
      if (pop_ok) begin
         rsp_dat_d     = i_wrbk_uc_dat_r;
         dealloc_vld_d = 1'b1;
         dealloc_ptr_d = cur_ctxt.head_ptr;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rsp_vld_q     <= '0;
         rsp_status_q  <= ST_OKAY;
         rsp_dat_q     <= '0;
         dealloc_vld_q <= 1'b0;
         dealloc_ptr_q <= '0;
      end else begin
         rsp_vld_q     <= rsp_vld_d;
         rsp_status_q  <= rsp_status_d;
         rsp_dat_q     <= rsp_dat_d;
         dealloc_vld_q <= dealloc_vld_d;
         dealloc_ptr_q <= dealloc_ptr_d;
      end
   end

   assign o_rsp_vld     = rsp_vld_q;
   assign o_rsp_status  = rsp_status_q;
   assign o_rsp_dat     = rsp_dat_q;
   assign o_dealloc_vld = dealloc_vld_q;
   assign o_dealloc_ptr = dealloc_ptr_q;

   for (genvar e = 0; e < ENGS_N; e++) begin : g_flat
      assign o_ctxt_head_vld_r[e]               = ctxt_r[e].head_vld;
      assign o_ctxt_head_ptr_r[e*PTR_W +: PTR_W] = ctxt_r[e].head_ptr;
      assign o_ctxt_tail_vld_r[e]               = ctxt_r[e].tail_vld;
      assign o_ctxt_tail_ptr_r[e*PTR_W +: PTR_W] = ctxt_r[e].tail_ptr;
      assign o_ctxt_cnt_r[e*CNT_W +: CNT_W]      = ctxt_r[e].cnt;
   end

   a_rsp_onehot0: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(rsp_vld_q));
   a_dealloc_after_pop: assert property (@(posedge clk) disable iff (!arst_n)
      dealloc_vld_q |-> $past(pop_ok));
   a_pop_head_vld: assert property (@(posedge clk) disable iff (!arst_n) pop_ok |-> cur_ctxt.head_vld);
   a_push_not_full: assert property (@(posedge clk) disable iff (!arst_n)
      push_ok |-> (cur_ctxt.cnt != CNT_MAX));
   a_pop_not_empty: assert property (@(posedge clk) disable iff (!arst_n)
      pop_ok |-> (cur_ctxt.cnt != cnt_t'(0)));

endmodule

// File: doc/stk_pipe_wrbk.md
Name: stk_pipe_wrbk

Overview:
- Writeback (WRBK) stage of the stack pipeline; sits directly downstream of the MEM stage and consumes the registered wrbk_uc_* bundle.
- Commits per-engine stack context (head pointer, tail pointer, occupancy) to an architectural context table.
- Returns the free-list pointer of a popped line to the allocator, and issues one per-engine response carrying status and pop data.
- Exposes committed context to the LK stage. AD and LK use the in-flight wrbk_uc_* signals as a bypass.

Parameters:
- ENGS_N, 4, number of engines; equals cfg_pkg::ENGS_N.
- PTR_W, 5, line pointer width; stack capacity 2**PTR_W lines.
- DAT_W, 128, payload width.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous assert, active-low.
- i_wrbk_uc_vld_r  in  1  writeback op valid.
- i_wrbk_uc_engid_r  in  $clog2(ENGS_N)  target engine.
- i_wrbk_uc_opcode_r  in  stk_pkg::opcode_t  NOP/PUSH/POP/CLR.
- i_wrbk_uc_status_r  in  stk_pkg::status_t  OKAY/FULL/EMPTY.
- i_wrbk_uc_head_vld_r  in  1  new head valid.
- i_wrbk_uc_head_ptr_r  in  PTR_W  new head pointer.
- i_wrbk_uc_tail_vld_r  in  1  new tail valid.
- i_wrbk_uc_tail_ptr_r  in  PTR_W  new tail pointer.
- i_wrbk_uc_dat_r  in  DAT_W  popped data.
- o_ctxt_head_vld_r  out  ENGS_N  committed head valid per engine.
- o_ctxt_head_ptr_r  out  ENGS_N*PTR_W  committed head pointers.
- o_ctxt_tail_vld_r  out  ENGS_N  committed tail valid.
- o_ctxt_tail_ptr_r  out  ENGS_N*PTR_W  committed tail pointers.
- o_ctxt_cnt_r  out  ENGS_N*(PTR_W+1)  occupancy per engine.
- o_dealloc_vld  out  1  free pointer valid; connects to AL i_dealloc_vld.
- o_dealloc_ptr  out  PTR_W  freed pointer.
- o_rsp_vld  out  ENGS_N  one-hot response strobe.
- o_rsp_status  out  stk_pkg::status_t  response status.
- o_rsp_dat  out  DAT_W  response data; valid on OKAY POP only.

Behaviour:
- All outputs are registered; latency is 1 cycle from i_wrbk_uc_vld_r to every output. There is no backpressure: the consumer accepts every response.
- Reset: all ctxt vld=0, ptrs=0, cnt=0, o_rsp_vld=0, o_dealloc_vld=0, o_rsp_status=OKAY, o_rsp_dat=0. An asynchronous reset mid-operation discards the in-flight op; no response and no dealloc are produced for it.
- Let e = engid. Every vld op with opcode != NOP produces o_rsp_vld[e]=1 for exactly one cycle and o_rsp_status=status. A NOP produces nothing.
- status != OKAY: context is unchanged, no dealloc, o_rsp_dat=0.
- OKAY PUSH:
  - head[e] <= {head_vld, head_ptr}; cnt[e]++.
  - If tail_vld=1 (first push onto an empty stack), tail[e] <= tail_ptr; otherwise tail is unchanged.
- OKAY POP:
  - o_dealloc_vld=1 and o_dealloc_ptr = committed head_ptr[e] (the pre-update value).
  - head[e] <= {head_vld, head_ptr}; cnt[e]--; o_rsp_dat = dat.
  - If head_vld=0, the stack has become empty: tail_vld[e] <= 0.
- OKAY CLR:
  - Resets engine e to empty (vld=0, cnt=0).
  - Issues no dealloc; line reclamation for CLR is out of scope.
  - Response status is OKAY.
- cnt arithmetic is PTR_W+1 bits and saturating:
  - A PUSH at cnt = 2**PTR_W holds the count and fires an assertion; upstream must have reported FULL.
  - A POP at cnt=0 holds the count and fires an assertion.
- Only one op arrives per cycle, so no intra-stage collision is possible. Context written in cycle N is visible on o_ctxt_* in cycle N+1.
- Assertions:
  - $onehot0(o_rsp_vld).
  - o_dealloc_vld implies the previous op was an OKAY POP.
  - On an OKAY POP, the engine's head_vld was 1 before the update.

Decomposition:
- stk_pkg: opcode_t, status_t, ptr_t (PTR_W), cnt_t (PTR_W+1), engid_t, and ctxt_t struct {head_vld, head_ptr, tail_vld, tail_ptr, cnt}.
- One sub-module, stk_pipe_wrbk_ctxt: the per-engine context register file with a single write port and a flat read-out.
- The top level holds the opcode/status decode, the dealloc logic and the response registers.

Test Plan:
- First push: reset, then PUSH e=1 OKAY head=3 tail_vld=1 tail=3 -> next cycle head[1]=3 vld, tail[1]=3 vld, cnt[1]=1, o_rsp_vld=4'b0010 status OKAY, o_dealloc_vld=0.
- Second push: PUSH e=1 head=7 tail_vld=0 -> head[1]=7, tail[1]=3 unchanged, cnt[1]=2.
- Pop to one element: POP e=1 OKAY head_vld=1 head=3 dat=0xA5A5 -> o_dealloc_vld=1 ptr=7, o_rsp_dat=0xA5A5, cnt[1]=1.
- Pop to empty: POP e=1 head_vld=0 -> dealloc ptr=3, head/tail vld[1]=0, cnt=0.
- Error op: POP e=2 status EMPTY -> o_rsp_vld=4'b0100 status EMPTY, no dealloc, engine 2 context unchanged.
- Back-to-back and reset: PUSH e0, PUSH e3, POP e0 on consecutive cycles -> three one-cycle responses in order with correct engine bits. Assert arst_n low during the POP -> all outputs 0 and all context cleared.
